line_motion_ctrl: RTL

LINE_MOTION_CTRL -- requirements
Module: line_motion_ctrl

---
 rtl/line_motion_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/line_motion_ctrl.sv
// rtl/line_motion_ctrl.sv - head motion, turn pulse, progress and game-state control for the line game
module line_motion_ctrl #(
  parameter logic [15:0] START_X  = 16'd336,
  parameter logic [15:0] START_Y  = 16'd240,
  parameter logic [15:0] SCREEN_X = 16'd320,
  parameter logic [15:0] SCREEN_Y = 16'd240,
  parameter logic [15:0] STEP     = 16'd2,
  parameter int          PROG_DIV = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        btn,
  input  logic        hit,
  output logic [15:0] head_x,
  output logic [15:0] head_y,
  output logic [15:0] scroll_x_in,
  output logic [15:0] scroll_y_in,
  output logic        press,
  output logic [9:0]  progress,
  output logic        tips_display,
  output logic        tips_display_over,
  output logic        win
);

  localparam int FW = (PROG_DIV > 1) ? $clog2(PROG_DIV) : 1;
  localparam logic [FW-1:0] FCNT_LAST = FW'(PROG_DIV - 1);
  localparam logic [9:0] PROG_MAX = 10'd999;

  typedef enum logic [1:0] {IDLE, RUN, OVER, WIN} state_t;

  state_t        state, state_n;
  logic          btn_d;
  logic          dir, dir_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic [9:0]    prog_n;
  logic [15:0]   hx_n, hy_n;
  logic          press_n;
  logic          edge_det;

  assign edge_det = btn & ~btn_d;

  // State register; reset overrides everything, including mid-run.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state and next-datapath values; a terminating tick wins over a turn.
  always_comb begin
    state_n = state;
    dir_n   = dir;
    fcnt_n  = fcnt;
    prog_n  = progress;
    hx_n    = head_x;
    hy_n    = head_y;
    press_n = 1'b0;
    case (state)
      IDLE: begin
        if (edge_det) state_n = RUN;
      end
      RUN: begin
        if (frame_tick) begin
          if (hit) begin
            state_n = OVER;
          end else begin
            if (dir) hy_n = head_y - STEP;
            else     hx_n = head_x + STEP;
            if (fcnt == FCNT_LAST) begin
              fcnt_n = '0;
              if (progress != PROG_MAX) prog_n = progress + 10'd1;
              if (prog_n == PROG_MAX) state_n = WIN;
            end else begin
              fcnt_n = fcnt + FW'(1);
            end
          end
        end
        if (edge_det && (state_n == RUN)) begin
          dir_n   = ~dir;
          press_n = 1'b1;
        end
      end
      OVER, WIN: begin
        if (edge_det) begin
          state_n = IDLE;
          hx_n    = START_X;
          hy_n    = START_Y;
          dir_n   = 1'b0;
          fcnt_n  = '0;
          prog_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath and output registers; scroll is derived from the next head so both update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_d             <= btn;
      dir               <= 1'b0;
      fcnt              <= '0;
      progress          <= '0;
      head_x            <= START_X;
      head_y            <= START_Y;
      scroll_x_in       <= START_X - SCREEN_X + 16'd1;
      scroll_y_in       <= START_Y - SCREEN_Y + 16'd1;
      press             <= 1'b0;
      tips_display      <= 1'b1;
      tips_display_over <= 1'b0;
      win               <= 1'b0;
    end else begin
      btn_d             <= btn;
      dir               <= dir_n;
      fcnt              <= fcnt_n;
      progress          <= prog_n;
      head_x            <= hx_n;
      head_y            <= hy_n;
      scroll_x_in       <= hx_n - SCREEN_X + 16'd1;
      scroll_y_in       <= hy_n - SCREEN_Y + 16'd1;
      press             <= press_n;
      tips_display      <= (state_n == IDLE);
      tips_display_over <= (state_n == OVER) || (state_n == WIN);
      win               <= (state_n == WIN);
    end
  end

endmodule
